// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Holds the FSM encoding, the x0 register index and the canonical NOP.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hzd_state_e;

    localparam logic [4:0]  X0        = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic logic src_match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: operand/hazard inputs from the pipeline and
// the stage enables, bubble controls and statistics back to it.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic             rs1_used_ID;
    logic             rs2_used_ID;
    logic             valid_ID;
    logic [4:0]       rd_EX;
    logic             MemRead_EX;
    logic             branch_taken_EX;
    logic             dmem_req_MEM;
    logic             dmem_ack_MEM;
    logic             en_PC;
    logic             en_IFID;
    logic             NOP_IFID;
    logic             en_IDEX;
    logic             NOP_IDEX;
    logic             en_EXMEM;
    logic             NOP_MEMWB;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, valid_ID,
               rd_EX, MemRead_EX, branch_taken_EX, dmem_req_MEM, dmem_ack_MEM,
        input  en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM, NOP_MEMWB,
               mem_timeout_err, stall_cycles, flush_count
    );

    modport slave (
        input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, valid_ID,
               rd_EX, MemRead_EX, branch_taken_EX, dmem_req_MEM, dmem_ack_MEM,
        output en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM, NOP_MEMWB,
               mem_timeout_err, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module hazard_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (clear)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: same-cycle stage gating,
// multi-cycle memory wait with watchdog, and stall/flush statistics.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input logic                   clk_HZD,
    input logic                   rst_HZD,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    hzd_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              load_use, mem_busy;
    logic              stall_inc, flush_inc;
    logic [6:0]        ctrl;

    assign load_use = hz.valid_ID && hz.MemRead_EX && (hz.rd_EX != X0) &&
                      (src_match(hz.rs1_used_ID, hz.rs1_ID, hz.rd_EX) ||
                       src_match(hz.rs2_used_ID, hz.rs2_ID, hz.rd_EX));

    assign mem_busy = (state_q == MEM_WAIT) ? !hz.dmem_ack_MEM
                                            : (hz.dmem_req_MEM && !hz.dmem_ack_MEM);

    // ctrl = {en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM, NOP_MEMWB}
    always_comb begin
        ctrl      = '0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (!rst_HZD && (state_q != ERROR)) begin
            if (mem_busy) begin
                ctrl      = 7'b0000001;
                stall_inc = 1'b1;
            end else if (hz.branch_taken_EX) begin
                ctrl      = 7'b1111110;
                flush_inc = 1'b1;
            end else if (load_use) begin
                ctrl      = 7'b0001110;
                stall_inc = 1'b1;
            end else begin
                ctrl      = 7'b1101010;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            RUN: begin
                if (hz.dmem_req_MEM && !hz.dmem_ack_MEM) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                // An ack landing on the timeout boundary still completes normally.
                if (hz.dmem_ack_MEM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_HZD) begin
        if (rst_HZD) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_HZD),
        .clear (rst_HZD),
        .inc   (stall_inc),
        .count (hz.stall_cycles)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_HZD),
        .clear (rst_HZD),
        .inc   (flush_inc),
        .count (hz.flush_count)
    );

    assign {hz.en_PC, hz.en_IFID, hz.NOP_IFID, hz.en_IDEX,
            hz.NOP_IDEX, hz.en_EXMEM, hz.NOP_MEMWB} = ctrl;
    assign hz.mem_timeout_err = err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) hz_if ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk_HZD (clk),
        .rst_HZD (rst),
        .hz      (hz_if.slave)
    );

    // {en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM, NOP_MEMWB}
    localparam logic [6:0] ZERO  = 7'b0000000;
    localparam logic [6:0] NORM  = 7'b1101010;
    localparam logic [6:0] LU    = 7'b0001110;
    localparam logic [6:0] FLUSH = 7'b1111110;
    localparam logic [6:0] BUSY  = 7'b0000001;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [6:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic v,
                        input logic [4:0] rd, input logic mr, input logic bt,
                        input logic req, input logic ack, input logic [6:0] e);
        logic [6:0] want;
        logic [6:0] seen;
        @(negedge clk);
        hz_if.rs1_ID          = rs1;
        hz_if.rs2_ID          = rs2;
        hz_if.rs1_used_ID     = u1;
        hz_if.rs2_used_ID     = u2;
        hz_if.valid_ID        = v;
        hz_if.rd_EX           = rd;
        hz_if.MemRead_EX      = mr;
        hz_if.branch_taken_EX = bt;
        hz_if.dmem_req_MEM    = req;
        hz_if.dmem_ack_MEM    = ack;
        exp_q.push_back(e);
        #2;
        seen = {hz_if.en_PC, hz_if.en_IFID, hz_if.NOP_IFID, hz_if.en_IDEX,
                hz_if.NOP_IDEX, hz_if.en_EXMEM, hz_if.NOP_MEMWB};
        want = exp_q.pop_front();
        chk(tag, 32'(seen), 32'(want));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [6:0] e);
        step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic counters(input string tag, input int unsigned s, input int unsigned f, input logic err);
        chk({tag, "_stall"}, 32'(hz_if.stall_cycles), s);
        chk({tag, "_flush"}, 32'(hz_if.flush_count), f);
        chk({tag, "_err"}, 32'(hz_if.mem_timeout_err), 32'(err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "bench timed out");
    end

    initial begin
        idle("rst0", ZERO);
        idle("rst1", ZERO);
        counters("after_rst", 0, 0, 1'b0);
        rst = 1'b0;

        // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then EX holds the bubble
        step("lu_rs1", 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU);
        counters("lu_rs1", 1, 0, 1'b0);
        step("lu_after", 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
        counters("lu_after", 1, 0, 1'b0);

        step("x0_load", 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM);
        step("lu_rs2", 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU);
        step("rs2_unused", 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, NORM);
        step("id_invalid", 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, NORM);
        counters("lu_mix", 2, 0, 1'b0);

        step("br_over_lu", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, FLUSH);
        counters("br_over_lu", 2, 1, 1'b0);

        // 3-cycle memory wait with a branch pending; ack lands on the timeout boundary
        step("mw0", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, BUSY);
        step("mw1", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, BUSY);
        step("mw2", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, BUSY);
        counters("mw_busy", 5, 1, 1'b0);
        step("mw_ack", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, FLUSH);
        counters("mw_ack", 5, 2, 1'b0);
        step("back_run", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
        step("single_acc", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM);
        step("single_next", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
        counters("single_acc", 5, 2, 1'b0);

        // hung memory: watchdog fires after the 4th busy cycle
        step("to0", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BUSY);
        step("to1", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BUSY);
        step("to2", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BUSY);
        counters("to_pre", 8, 2, 1'b0);
        step("to3", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BUSY);
        counters("to_err", 9, 2, 1'b1);
        step("err_freeze", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, ZERO);
        idle("err_idle", ZERO);
        counters("err_hold", 9, 2, 1'b1);

        rst = 1'b1;
        idle("err_rst", ZERO);
        counters("err_rst", 0, 0, 1'b0);
        rst = 1'b0;
        idle("post_rst", NORM);

        for (int i = 0; i < 20; i++)
            step("lu_sat", 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LU);
        counters("lu_sat", 15, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the enable and NOP (bubble) inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Resolves load-use hazards, taken-branch/jump flushes and multi-cycle data-memory waits, with a watchdog for hung memory.
- Keeps saturating performance counters for stalls and flushes.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before entering ERROR (≥2)
CNT_W, 32, width of saturating performance counters

Ports:
clk_HZD  in  1  pipeline clock
rst_HZD  in  1  synchronous, active-high reset
rs1_ID  in  5  rs1 field of instruction in ID
rs2_ID  in  5  rs2 field of instruction in ID
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
valid_ID  in  1  IF/ID slot holds a real instruction
rd_EX  in  5  destination reg of instruction in EX
MemRead_EX  in  1  EX instruction is a load
branch_taken_EX  in  1  branch/jump in EX redirects the PC this cycle
dmem_req_MEM  in  1  MEM-stage data-memory request active
dmem_ack_MEM  in  1  data memory completes the request this cycle
en_PC  out  1  PC write enable
en_IFID  out  1  IF/ID enable
NOP_IFID  out  1  IF/ID bubble insert
en_IDEX  out  1  ID/EX enable
NOP_IDEX  out  1  ID/EX bubble insert
en_EXMEM  out  1  EX/MEM enable
NOP_MEMWB  out  1  MEM/WB bubble insert
mem_timeout_err  out  1  sticky watchdog error
stall_cycles  out  CNT_W  saturating count of stalled cycles
flush_count  out  CNT_W  saturating count of branch flushes

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR.
  - State, wait counter and performance counters are registered.
  - en_*/NOP_* are combinational from state and current inputs, giving same-cycle gating with zero latency.
- Reset (sync, checked at posedge): state=RUN, wait_cnt=0, mem_timeout_err=0, stall_cycles=0, flush_count=0.
  - While rst_HZD=1, all en_*=0 and all NOP_*=0. Stage registers reset themselves.
  - Reset asserted mid-MEM_WAIT or in ERROR returns to RUN on the next edge.
- mem_busy = dmem_req_MEM & ~dmem_ack_MEM (RUN) or ~dmem_ack_MEM (MEM_WAIT).
- Action priority per cycle: ERROR > mem_busy > branch flush > load-use > normal.
  - ERROR: all en_*=0, all NOP_*=0. The pipeline is frozen until reset.
  - mem_busy: en_PC=en_IFID=en_IDEX=en_EXMEM=0, NOP_IFID=NOP_IDEX=0, NOP_MEMWB=1.
    - MEM/WB receives a bubble so WB never sees a repeated commit.
    - A pending branch_taken_EX is held frozen and acted on after the ack.
  - Branch flush (branch_taken_EX=1, not busy): all en=1, NOP_IFID=1, NOP_IDEX=1. This squashes the two younger instructions.
    - A load-use hazard in the same cycle is ignored, because the ID instruction is squashed.
  - Load-use: hazard condition is valid_ID & MemRead_EX & rd_EX≠0 & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
    - en_PC=0, en_IFID=0, NOP_IDEX=1, en_EXMEM=1, NOP_IFID=0, NOP_MEMWB=0.
    - Exactly one bubble is inserted per load; the next cycle the hazard term is false because EX holds the bubble.
  - Normal: en_PC=en_IFID=en_IDEX=en_EXMEM=1, all NOP_*=0.
- Transitions:
  - RUN→MEM_WAIT when dmem_req_MEM & ~dmem_ack_MEM; wait_cnt←1.
  - MEM_WAIT→RUN on dmem_ack_MEM. The ack cycle is not busy, so the pipeline advances that same cycle.
  - MEM_WAIT with no ack: wait_cnt++. When wait_cnt==MEM_TIMEOUT-1 and no ack → ERROR, mem_timeout_err←1.
  - Ack on the same cycle as the timeout boundary wins and the FSM returns to RUN.
  - A single-cycle access (req & ack together in RUN) causes no stall and no state change.
- Counters:
  - stall_cycles += 1 on every mem_busy or load-use cycle.
  - flush_count += 1 on every effective branch flush.
  - Both saturate at 2^CNT_W-1 with no wrap. ERROR cycles are not counted.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2)
  - x0 constant (5'd0)
  - NOP instruction constant 32'h00000013
- One sub-module: hazard_sat_counter (CNT_W-wide, inc, clear, saturate), instantiated twice.

Test Plan:
- lw x5 in EX with MemRead_EX=1, rd_EX=5, and add x6,x5,x1 in ID (rs1_ID=5, rs1_used_ID=1) → exactly 1 cycle of en_PC=en_IFID=0, NOP_IDEX=1; stall_cycles=1.
- rd_EX=0 with MemRead_EX=1 and rs1_ID=0 → no stall; all en=1.
- branch_taken_EX=1 while the load-use condition is also true → NOP_IFID=NOP_IDEX=1, all en=1; flush_count=1, stall_cycles unchanged.
- dmem_req_MEM=1 with ack after 3 cycles → en_*=0 and NOP_MEMWB=1 for 3 cycles, normal on the ack cycle, state back in RUN; stall_cycles=3.
- MEM_TIMEOUT=4, req held with no ack → ERROR after wait_cnt reaches 3, mem_timeout_err=1, all en=0; rst_HZD pulse → RUN, err=0, counters=0.
- CNT_W=4, 20 load-use stalls → stall_cycles holds at 15.
